piano_rec_player: RTL and testbench
===================================

Name: piano_rec_player

Overview:
- Parametrised successor of the MiniPiano note path. Encodes an N-key keyboard plus octave into a note code.
- Adds a record/playback engine: key presses are captured as (note, octave, duration) segments in an internal buffer and replayed with their original timing.
- Sits between the key inputs and the buzzer/LED/segment consumers. note_out/octave_out drive the buzzer, led mirrors the active note.

Parameters:
- NUM_KEYS, 7, number of piano keys (1..15); note code width is 4.
- OCT_W, 2, octave select width.
- DEPTH, 64, segment buffer entries (power of 2).
- DUR_W, 12, duration field width, in ticks.
- TICK_DIV, 1000000, clk cycles per duration tick (10 ms at 100 MHz).

Ports:
- clk, in, 1, system clock.
- reset, in, 1, synchronous active-high reset.
- keys, in, NUM_KEYS, key inputs, 1 = pressed.
- octave, in, OCT_W, live octave select.
- mode, in, 2, 00 live, 01 record, 10 play, 11 idle/mute.
- start, in, 1, single-cycle pulse: begin record (mode 01) or playback (mode 10).
- note_out, out, 4, 0 = rest, k+1 = key k.
- octave_out, out, OCT_W, octave of note_out.
- led, out, NUM_KEYS, one-hot of the active note; 0 on rest.
- busy, out, 1, REC or PLAY state active.
- full, out, 1, buffer filled during last record.
- done, out, 1, one-cycle pulse at playback end.
- count, out, $clog2(DEPTH)+1, stored segment count.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset.
- Reset: all outputs 0, state IDLE, count 0, tick counter 0. Buffer contents are don't-care.
- Key encode: lowest-index pressed key wins, giving note = index+1; no key gives 0.
- Tick: a counter of TICK_DIV cycles produces a one-cycle tick pulse. The counter is cleared on any accepted start.
- States: IDLE, REC, PLAY.
- IDLE:
  - mode 00: note_out/octave_out = registered encode, 1-cycle latency.
  - other modes: outputs 0.
  - start with mode 01 → REC, count cleared to 0, full cleared.
  - start with mode 10 → PLAY at index 0.
  - start with mode 00/11 is ignored.
- REC:
  - Outputs follow live keys (monitoring).
  - Current segment = (cur_note, cur_oct, dur). dur increments on tick and saturates.
  - Segment end: the encoded (note, octave) differs from cur, or dur reaches 2^DUR_W−1.
  - On segment end, write {cur_note, cur_oct, dur} at index count, count++, then open a new segment with dur = 0.
  - Segments with dur = 0 are discarded (glitch filter; no write).
  - Saturation split keeps the same note in the new segment.
  - count reaches DEPTH → full = 1, go to IDLE.
  - mode leaves 01 → flush the open segment if dur > 0 and not full, then go to IDLE.
- PLAY:
  - Entry i is shown on note_out/octave_out for exactly dur ticks.
  - First entry appears on the cycle after start.
  - After entry count−1 expires: note_out = 0, done pulse, go to IDLE.
  - count = 0 → done pulse the cycle after start, no note output.
  - mode leaves 10 mid-play → abort to IDLE next cycle, outputs 0, no done pulse.
- start while busy is ignored.
- Reset mid-REC/PLAY → IDLE, count 0.
- busy = (state != IDLE).

Optional Feature:
- LOOP_PLAY_EN: when defined, PLAY wraps from the last entry to index 0 and continues until mode leaves 10. done pulses at each wrap.
- Without it, playback stops after one pass as described above.
- An empty buffer yields a single done pulse in both builds.

Test Plan:
1. Live mode: TICK_DIV = 4. Hold keys = 0000101 → note_out = 1 one cycle later, led = 0000001. Release → note_out = 0.
2. Record: mode 01, start. key2 held 3 ticks, rest 2 ticks, key5 held 4 ticks, mode → 00. Result: count = 3, entries {3,oct,3}, {0,oct,2}, {6,oct,4}.
3. Playback of test 2: mode 10, start → note_out = 3 for 12 cycles, then 0 for 8, then 6 for 16. Then done pulse, busy = 0.
4. Overflow: DEPTH = 4, toggle keys each tick → full = 1 after the 4th write, state IDLE, count = 4.
5. Saturation: DUR_W = 2, hold key0 for 7 ticks → entries {1,3}, {1,3}, {1,1}.
6. Abort: mode 10 → 11 mid-play → note_out = 0 next cycle, no done. Empty-buffer start → done the cycle after start.

Source files
------------

// File: rtl/piano_rec_player.sv
// piano_rec_player: N-key keyboard note encoder with a record/playback engine.
//   Live mode encodes the lowest pressed key (note = index+1, 0 = rest).
//   Record mode captures (note, octave, duration-in-ticks) segments into a buffer.
//   Play mode replays the stored segments with their original timing.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   keys, octave        : live key inputs (1 = pressed) and octave select
//   mode                : 00 live, 01 record, 10 play, 11 idle/mute
//   start               : one-cycle pulse that begins record or playback
//   note_out/octave_out : buzzer drive; led is one-hot of the active note
//   busy, full, done    : REC/PLAY active, buffer filled, end-of-playback pulse
//   count               : number of stored segments
// Build option: define LOOP_PLAY_EN to make playback wrap until mode leaves 10.
module piano_rec_player #(
  parameter int unsigned NUM_KEYS = 7,
  parameter int unsigned OCT_W    = 2,
  parameter int unsigned DEPTH    = 64,
  parameter int unsigned DUR_W    = 12,
  parameter int unsigned TICK_DIV = 1000000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_KEYS-1:0]      keys,
  input  logic [OCT_W-1:0]         octave,
  input  logic [1:0]               mode,
  input  logic                     start,
  output logic [3:0]               note_out,
  output logic [OCT_W-1:0]         octave_out,
  output logic [NUM_KEYS-1:0]      led,
  output logic                     busy,
  output logic                     full,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned EW = 4 + OCT_W + DUR_W;
  localparam logic [DUR_W-1:0] DUR_MAX = '1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REC  = 2'd1;
  localparam logic [1:0] S_PLAY = 2'd2;

  localparam logic [1:0] M_LIVE = 2'b00;
  localparam logic [1:0] M_REC  = 2'b01;
  localparam logic [1:0] M_PLAY = 2'b10;

  logic [1:0]          state_q, state_d;
  logic [TW-1:0]       tick_cnt_q, tick_cnt_d;
  logic [3:0]          cur_note_q, cur_note_d;
  logic [OCT_W-1:0]    cur_oct_q, cur_oct_d;
  logic [DUR_W-1:0]    dur_q, dur_d;
  logic [AW-1:0]       idx_q, idx_d;
  logic [DUR_W-1:0]    pdur_q, pdur_d;
  logic [CW-1:0]       count_q, count_d;
  logic                full_q, full_d;
  logic                done_q, done_d;
  logic                busy_q;
  logic [3:0]          note_q, note_d;
  logic [OCT_W-1:0]    oct_q, oct_d;
  logic [NUM_KEYS-1:0] led_q, led_d;

  logic [EW-1:0]       mem_q [DEPTH];
  logic                wr_en_c;
  logic [3:0]          enc_note_c;
  logic                tick_c;
  logic                seg_end_c;
  logic [DUR_W-1:0]    cur_dur_c;
  logic                expire_c;
  logic                at_last_c;
  logic [AW-1:0]       nxt_idx_c;
  logic [3:0]          rd_note_c;
  logic [OCT_W-1:0]    rd_oct_c;

  // Lowest-index pressed key wins
  always_comb begin
    enc_note_c = 4'd0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (keys[i]) enc_note_c = 4'(i + 1);
    end
  end

  assign tick_c    = (tick_cnt_q == TW'(TICK_DIV - 1));
  assign seg_end_c = (enc_note_c != cur_note_q) || (octave != cur_oct_q) || (dur_q == DUR_MAX);

  // Playback sequencing kept outside the main block so the read index is loop-free
  assign cur_dur_c = mem_q[idx_q][DUR_W-1:0];
  assign expire_c  = (state_q == S_PLAY) && tick_c && ((pdur_q + DUR_W'(1)) == cur_dur_c);
  assign at_last_c = (idx_q == AW'(count_q - CW'(1)));
  assign nxt_idx_c = (state_q != S_PLAY) ? '0 :
                     (expire_c ? (at_last_c ? '0 : idx_q + AW'(1)) : idx_q);
  assign rd_note_c = mem_q[nxt_idx_c][EW-1 -: 4];
  assign rd_oct_c  = mem_q[nxt_idx_c][DUR_W +: OCT_W];

  // Next-state and output logic
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_c ? '0 : tick_cnt_q + TW'(1);
    cur_note_d = cur_note_q;
    cur_oct_d  = cur_oct_q;
    dur_d      = dur_q;
    idx_d      = nxt_idx_c;
    pdur_d     = pdur_q;
    count_d    = count_q;
    full_d     = full_q;
    done_d     = 1'b0;
    note_d     = 4'd0;
    oct_d      = '0;
    wr_en_c    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (mode == M_LIVE) begin
          note_d = enc_note_c;
          oct_d  = octave;
        end
        if (start && mode == M_REC) begin
          state_d    = S_REC;
          tick_cnt_d = '0;
          count_d    = '0;
          full_d     = 1'b0;
          cur_note_d = enc_note_c;
          cur_oct_d  = octave;
          dur_d      = '0;
        end else if (start && mode == M_PLAY) begin
          tick_cnt_d = '0;
          pdur_d     = '0;
          if (count_q == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = S_PLAY;
            note_d  = rd_note_c;
            oct_d   = rd_oct_c;
          end
        end
      end

      S_REC: begin
        if (mode != M_REC) begin
          wr_en_c = (dur_q != '0);
          state_d = S_IDLE;
        end else begin
          if (seg_end_c) begin
            // Zero-length segments are glitches and are dropped
            wr_en_c    = (dur_q != '0);
            cur_note_d = enc_note_c;
            cur_oct_d  = octave;
            dur_d      = '0;
          end else if (tick_c && dur_q != DUR_MAX) begin
            dur_d = dur_q + DUR_W'(1);
          end
          note_d = enc_note_c;
          oct_d  = octave;
        end
        if (wr_en_c) begin
          count_d = count_q + CW'(1);
          if (count_d == CW'(DEPTH)) begin
            full_d  = 1'b1;
            state_d = S_IDLE;
            note_d  = 4'd0;
            oct_d   = '0;
          end
        end
      end

      S_PLAY: begin
        if (mode != M_PLAY) begin
          state_d = S_IDLE;
        end else begin
          if (expire_c) begin
            pdur_d = '0;
            if (at_last_c) begin
              done_d = 1'b1;
`ifndef LOOP_PLAY_EN
              state_d = S_IDLE;
`endif
            end
          end else if (tick_c) begin
            pdur_d = pdur_q + DUR_W'(1);
          end
          if (state_d == S_PLAY) begin
            note_d = rd_note_c;
            oct_d  = rd_oct_c;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    led_d = (note_d == 4'd0) ? '0 : (NUM_KEYS'(1) << (note_d - 4'd1));
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      tick_cnt_q <= '0;
      cur_note_q <= 4'd0;
      cur_oct_q  <= '0;
      dur_q      <= '0;
      idx_q      <= '0;
      pdur_q     <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      note_q     <= 4'd0;
      oct_q      <= '0;
      led_q      <= '0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      cur_note_q <= cur_note_d;
      cur_oct_q  <= cur_oct_d;
      dur_q      <= dur_d;
      idx_q      <= idx_d;
      pdur_q     <= pdur_d;
      count_q    <= count_d;
      full_q     <= full_d;
      done_q     <= done_d;
      busy_q     <= (state_d != S_IDLE);
      note_q     <= note_d;
      oct_q      <= oct_d;
      led_q      <= led_d;
    end
  end

  // Segment buffer, written at the current count
  always_ff @(posedge clk) begin
    if (wr_en_c) mem_q[count_q[AW-1:0]] <= {cur_note_q, cur_oct_q, dur_q};
  end

  assign note_out   = note_q;
  assign octave_out = oct_q;
  assign led        = led_q;
  assign busy       = busy_q;
  assign full       = full_q;
  assign done       = done_q;
  assign count      = count_q;

endmodule

// File: tb/tb_piano_rec_player.sv
// Directed bench for piano_rec_player. Instance a uses DEPTH=64/DUR_W=12,
// instance b uses DEPTH=4/DUR_W=2; both run TICK_DIV=4 on shared inputs.
module tb_piano_rec_player;
  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] keys;
  logic [1:0] octave;
  logic [1:0] mode;
  logic       start;

  logic [3:0] note_a, note_b;
  logic [1:0] oct_a, oct_b;
  logic [6:0] led_a, led_b;
  logic       busy_a, busy_b, full_a, full_b, done_a, done_b;
  logic [6:0] count_a;
  logic [2:0] count_b;

  int nvec = 0;
  int nmiss = 0;

  always #5 clk = ~clk;

  piano_rec_player #(.NUM_KEYS(7), .OCT_W(2), .DEPTH(64), .DUR_W(12), .TICK_DIV(4)) u_a (
    .clk(clk), .reset(reset), .keys(keys), .octave(octave), .mode(mode), .start(start),
    .note_out(note_a), .octave_out(oct_a), .led(led_a), .busy(busy_a), .full(full_a),
    .done(done_a), .count(count_a));

  piano_rec_player #(.NUM_KEYS(7), .OCT_W(2), .DEPTH(4), .DUR_W(2), .TICK_DIV(4)) u_b (
    .clk(clk), .reset(reset), .keys(keys), .octave(octave), .mode(mode), .start(start),
    .note_out(note_b), .octave_out(oct_b), .led(led_b), .busy(busy_b), .full(full_b),
    .done(done_b), .count(count_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmiss++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; keys = '0; octave = '0; mode = 2'b11; start = 1'b0;
    cyc(2);
    chk("rst_note", 32'(note_a), 0);
    chk("rst_led", 32'(led_a), 0);
    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_full", 32'(full_a), 0);
    chk("rst_done", 32'(done_a), 0);
    chk("rst_count", 32'(count_a), 0);

    // Live mode
    reset = 1'b0; mode = 2'b00;
    cyc(1);
    keys = 7'b0000101; octave = 2'd2;
    chk("live_latency", 32'(note_a), 0);
    cyc(1);
    chk("live_note", 32'(note_a), 1);
    chk("live_led", 32'(led_a), 1);
    chk("live_oct", 32'(oct_a), 2);
    keys = '0;
    cyc(1);
    chk("live_release", 32'(note_a), 0);
    chk("live_led_rest", 32'(led_a), 0);

    // Record: key2 3 ticks, rest 2 ticks, key5 4 ticks
    keys = 7'b0000100; octave = 2'd1; mode = 2'b01; start = 1'b1;
    cyc(1); start = 1'b0;
    cyc(1);
    chk("rec_busy", 32'(busy_a), 1);
    chk("rec_monitor", 32'(note_a), 3);
    chk("rec_count0", 32'(count_a), 0);
    cyc(11); keys = '0;
    cyc(1);
    chk("rec_count1", 32'(count_a), 1);
    cyc(7); keys = 7'b0100000;
    cyc(1);
    chk("rec_count2", 32'(count_a), 2);
    chk("rec_monitor6", 32'(note_a), 6);
    cyc(15); mode = 2'b00; keys = '0;
    cyc(1);
    chk("rec_count3", 32'(count_a), 3);
    chk("rec_exit_busy", 32'(busy_a), 0);
    chk("rec_full", 32'(full_a), 0);

    // Playback: 3 for 12 cycles, rest for 8, 6 for 16
    mode = 2'b10; start = 1'b1;
    cyc(1); start = 1'b0;
    chk("play_first", 32'(note_a), 3);
    chk("play_oct", 32'(oct_a), 1);
    chk("play_led", 32'(led_a), 32'h4);
    chk("play_busy", 32'(busy_a), 1);
    cyc(5); start = 1'b1;
    cyc(1); start = 1'b0;
    cyc(5);
    chk("play_e0_end", 32'(note_a), 3);
    cyc(1);
    chk("play_e1_start", 32'(note_a), 0);
    chk("play_e1_busy", 32'(busy_a), 1);
    cyc(7);
    chk("play_e1_end", 32'(note_a), 0);
    cyc(1);
    chk("play_e2_start", 32'(note_a), 6);
    cyc(15);
    chk("play_e2_end", 32'(note_a), 6);
    chk("play_no_early_done", 32'(done_a), 0);
    cyc(1);
    chk("play_end_note", 32'(note_a), 0);
    chk("play_done", 32'(done_a), 1);
    chk("play_end_busy", 32'(busy_a), 0);
    cyc(1);
    chk("play_done_pulse", 32'(done_a), 0);

    // Overflow on the 4-deep instance
    reset = 1'b1; keys = '0; mode = 2'b01;
    cyc(1);
    reset = 1'b0; keys = 7'b0000001; start = 1'b1;
    cyc(1); start = 1'b0;
    cyc(4); keys = '0;
    cyc(4); keys = 7'b0000001;
    cyc(4); keys = '0;
    cyc(4); keys = 7'b0000001;
    chk("ovf_count3", 32'(count_b), 3);
    chk("ovf_not_full", 32'(full_b), 0);
    chk("ovf_busy", 32'(busy_b), 1);
    cyc(1);
    chk("ovf_full", 32'(full_b), 1);
    chk("ovf_idle", 32'(busy_b), 0);
    chk("ovf_count4", 32'(count_b), 4);

    // Saturation split with DUR_W=2: key0 held 7 ticks -> 3,3,1
    reset = 1'b1; keys = 7'b0000001; octave = 2'd0; mode = 2'b01;
    cyc(1);
    reset = 1'b0; start = 1'b1;
    cyc(1); start = 1'b0;
    cyc(12);
    chk("sat_before_split", 32'(count_b), 0);
    cyc(1);
    chk("sat_split1", 32'(count_b), 1);
    cyc(12);
    chk("sat_split2", 32'(count_b), 2);
    cyc(3); keys = '0;
    chk("sat_hold", 32'(count_b), 2);
    cyc(1);
    chk("sat_count3", 32'(count_b), 3);
    chk("sat_not_full", 32'(full_b), 0);
    mode = 2'b00;
    cyc(1);
    mode = 2'b10; start = 1'b1;
    cyc(1); start = 1'b0;
    chk("sat_play_first", 32'(note_b), 1);
    chk("sat_play_a", 32'(note_a), 1);
    cyc(27);
    chk("sat_play_last", 32'(note_b), 1);
    chk("sat_play_nodone", 32'(done_b), 0);
    cyc(1);
    chk("sat_play_end", 32'(note_b), 0);
    chk("sat_play_done", 32'(done_b), 1);

    // Abort mid-play
    cyc(1); start = 1'b1;
    cyc(1); start = 1'b0;
    chk("abort_playing", 32'(note_a), 1);
    chk("abort_busy", 32'(busy_a), 1);
    cyc(4); mode = 2'b11;
    cyc(1);
    chk("abort_note", 32'(note_a), 0);
    chk("abort_idle", 32'(busy_a), 0);
    chk("abort_nodone", 32'(done_a), 0);
    for (int i = 0; i < 8; i++) begin
      cyc(4);
      chk("abort_nodone_later", 32'(done_a), 0);
    end

    // Empty buffer playback
    reset = 1'b1; mode = 2'b10;
    cyc(1);
    reset = 1'b0; start = 1'b1;
    cyc(1); start = 1'b0;
    chk("empty_done", 32'(done_a), 1);
    chk("empty_busy", 32'(busy_a), 0);
    chk("empty_note", 32'(note_a), 0);
    cyc(1);
    chk("empty_done_pulse", 32'(done_a), 0);
    chk("empty_idle", 32'(busy_a), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
    $finish;
  end
endmodule
